vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Upstream stage of the TinyVGA output path. Free-running 640x480@60 raster timing
//  generator with a built-in test-pattern source.
//  Produces hsync/vsync, video_active, pixel coordinates and a frame counter.
//  Emits one packed 8-bit TinyVGA bus in the exact bit order the PCG colour-mixing
//  output stage consumes on its dedicated inputs.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line;  H_FP 16 front porch;  H_SYNC 96 sync width;  H_BP 48 back porch
//  V_ACTIVE 480 visible lines;        V_FP 10;              V_SYNC 2;               V_BP 33
//  SYNC_POL 0   sync asserted level (0 = active-low, standard for 640x480)
//  FRAME_W  8   frame counter width
// PORTS
//  clk          in   1   pixel clock (25.175 MHz nominal)
//  rst_n        in   1   asynchronous, active-low reset
//  en           in   1   pixel enable; all state advances only when 1
//  pattern_sel  in   2   0 black, 1 colour bars, 2 checkerboard, 3 scrolling gradient
//  hpos         out  10  current horizontal counter, 0..H_TOTAL-1
//  vpos         out  10  current vertical counter, 0..V_TOTAL-1
//  frame_cnt    out  FRAME_W  completed-frame count, wraps
//  line_start   out  1   1-cycle pulse, registered, when hpos wraps to 0
//  frame_start  out  1   1-cycle pulse, registered, when (hpos,vpos) wraps to (0,0)
//  hsync        out  1   horizontal sync at SYNC_POL
//  vsync        out  1   vertical sync at SYNC_POL
//  video_active out  1   1 inside the visible window
//  vga_bus      out  8   {R1,G1,B1,vsync,R0,G0,B0,hsync}: bit0 hsync, bit4 vsync
// BEHAVIOUR
//  - Totals: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
//  - Reset (async assert, sync deassert edge is the designer's job upstream):
//    - hpos = vpos = frame_cnt = 0; line_start = frame_start = 0; video_active = 0.
//    - hsync = vsync = ~SYNC_POL; vga_bus = sync bits inactive, RGB = 0.
//    - Latched pattern = 0.
//  - Counters, on each clk with en=1:
//    - hpos++; at H_TOTAL-1 hpos -> 0 and vpos++.
//    - At vpos = V_TOTAL-1 with hpos wrap, vpos -> 0 and frame_cnt++ (wraps at 2^FRAME_W-1 -> 0).
//  - en=0: every register holds; line_start/frame_start are forced 0 that cycle.
//  - Output latency: hsync, vsync, video_active, vga_bus, line_start and frame_start are
//    registered from the current (hpos,vpos). They lag hpos/vpos by exactly one enabled cycle.
//  - Decode ranges (on the counter value):
//    - active = hpos < H_ACTIVE && vpos < V_ACTIVE.
//    - hsync asserted for H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC (656..751).
//    - vsync asserted for V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC (490..491).
//  - Pattern: pattern_sel is sampled only on the enabled cycle where counters wrap to (0,0).
//    A mid-frame change never alters the current frame.
//  - Colour (6-bit RRGGBB, computed from hpos/vpos/frame_cnt):
//    - bars: 8 bars of 80 px indexed by hpos/80; bar i -> {i[2],i[2],i[1],i[1],i[0],i[0]}.
//    - checker: all 1s when hpos[5]^vpos[5], else 0.
//    - gradient: R = (hpos+frame_cnt)[7:6], G = vpos[7:6], B = (hpos-frame_cnt)[7:6].
//  - Blanking: RGB bits of vga_bus forced 0 whenever active=0. Sync bits always driven.
//  - Counters never exceed totals. Any out-of-range value (e.g. SEU) wraps to 0 on the next enabled cycle.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//    - 640x480 default timing constants and derived H_TOTAL/V_TOTAL.
//    - vga_bus bit-index localparams (shared with the output/mixing stage).
//    - Pattern-select encodings PAT_BLACK/PAT_BARS/PAT_CHECK/PAT_GRAD.
//  - One sub-module: vga_pattern_gen (combinational hpos/vpos/frame_cnt/pattern -> 6-bit RGB).
//    Counters, decode and output registers stay in vga_timing_gen.
// TESTING
//  1. Reset: hold rst_n=0 mid-line (hpos=300) -> all outputs at reset values next sample;
//     release -> hpos counts 0,1,2 on enabled cycles.
//  2. Line timing, en=1: hsync low for exactly 96 cycles; first low output sample is 1 cycle
//     after hpos=656. line_start pulses once per 800 cycles.
//  3. Frame timing: vsync low for exactly 2 lines (1600 cycles). frame_start period = 420000 cycles.
//     frame_cnt 255 -> 0 after 256 frames (FRAME_W=8).
//  4. en gating: toggle en 1/0 -> hpos advances only on en=1; no pulse outputs while en=0;
//     period in enabled cycles unchanged.
//  5. Pattern: sel=1 -> vga_bus RGB for hpos=0 is 0, for hpos=639 is all 1s; RGB = 0 at hpos=640.
//     Switch sel=2 at vpos=100 -> bars persist until frame_start, then checker.
//  6. Bus order: at hpos=700, vpos=490, pattern 0 -> vga_bus = 8'b0000_0000 (both syncs low, SYNC_POL=0).
//     At hpos=10, vpos=10 -> bits 0 and 4 set.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480 timing constants, bus layout and pattern encodings
//
// Purpose: constants shared by the raster timing generator and the downstream
// TinyVGA colour-mixing stage.
//   VGA_*          default 640x480@60 timing and derived totals
//   BUS_*          bit positions inside the packed 8-bit TinyVGA bus
//   pattern_e      test-pattern select encodings
//   rgb_t          6-bit RRGGBB colour
//   pack_bus()     places colour and sync bits into the TinyVGA bus order
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam bit          VGA_SYNC_POL = 1'b0;
  localparam int unsigned VGA_FRAME_W  = 8;
  localparam int unsigned POS_W        = 10;

  // TinyVGA bus: {R1,G1,B1,vsync,R0,G0,B0,hsync}
  localparam int unsigned BUS_HSYNC = 0;
  localparam int unsigned BUS_B0    = 1;
  localparam int unsigned BUS_G0    = 2;
  localparam int unsigned BUS_R0    = 3;
  localparam int unsigned BUS_VSYNC = 4;
  localparam int unsigned BUS_B1    = 5;
  localparam int unsigned BUS_G1    = 6;
  localparam int unsigned BUS_R1    = 7;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_GRAD  = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  function automatic logic [7:0] pack_bus(input rgb_t rgb, input logic hs, input logic vs);
    logic [7:0] bus;
    bus            = '0;
    bus[BUS_R1]    = rgb.r[1];
    bus[BUS_G1]    = rgb.g[1];
    bus[BUS_B1]    = rgb.b[1];
    bus[BUS_VSYNC] = vs;
    bus[BUS_R0]    = rgb.r[0];
    bus[BUS_G0]    = rgb.g[0];
    bus[BUS_B0]    = rgb.b[0];
    bus[BUS_HSYNC] = hs;
    return bus;
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - combinational test-pattern colour source
//
// Purpose: maps the current raster position, frame count and latched pattern
// to a 6-bit colour. Blanking is applied by the caller.
// Ports:
//   hpos       in   10        horizontal counter
//   vpos       in   10        vertical counter
//   frame_cnt  in   FRAME_W   completed-frame count (drives gradient scroll)
//   pattern    in   pattern_e selected pattern for this frame
//   rgb        out  rgb_t     RRGGBB colour
module vga_pattern_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FRAME_W  = VGA_FRAME_W
) (
  input  logic [POS_W-1:0]   hpos,
  input  logic [POS_W-1:0]   vpos,
  input  logic [FRAME_W-1:0] frame_cnt,
  input  pattern_e           pattern,
  output rgb_t               rgb
);

  // Eight equal bars across the visible width.
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  logic [7:0] frame_lo;
  logic [7:0] grad_r;
  logic [7:0] grad_b;
  logic       unused_bits;

  assign bar_idx  = 3'(hpos / POS_W'(BAR_W));
  assign frame_lo = 8'(frame_cnt);
  // Only bits [7:6] of these sums matter, so 8-bit modular arithmetic is exact.
  assign grad_r   = hpos[7:0] + frame_lo;
  assign grad_b   = hpos[7:0] - frame_lo;

  assign unused_bits = ^{vpos[9:8], vpos[4:0], grad_r[5:0], grad_b[5:0]};

  always_comb begin
    rgb = '0;
    case (pattern)
      PAT_BLACK: rgb = '0;
      PAT_BARS:  rgb = {bar_idx[2], bar_idx[2], bar_idx[1], bar_idx[1], bar_idx[0], bar_idx[0]};
      PAT_CHECK: rgb = (hpos[5] ^ vpos[5]) ? 6'h3F : 6'h00;
      PAT_GRAD:  rgb = {grad_r[7:6], vpos[7:6], grad_b[7:6]};
      default:   rgb = '0;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running raster timing generator with test-pattern source
//
// Purpose: counts pixels/lines of a 640x480@60 raster, decodes sync and active
// window, and drives the packed TinyVGA bus with a selectable test pattern.
// Ports:
//   clk           in   1        pixel clock
//   rst_n         in   1        asynchronous active-low reset
//   en            in   1        pixel enable, all state advances only when 1
//   pattern_sel   in   2        pattern request, taken at each frame wrap
//   hpos, vpos    out  10       raster counters
//   frame_cnt     out  FRAME_W  completed-frame count, wraps
//   line_start    out  1        pulse with the output cycle of pixel 0 of a line
//   frame_start   out  1        pulse with the output cycle of pixel (0,0)
//   hsync, vsync  out  1        sync at SYNC_POL when asserted
//   video_active  out  1        inside the visible window
//   vga_bus       out  8        {R1,G1,B1,vsync,R0,G0,B0,hsync}
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          SYNC_POL = VGA_SYNC_POL,
  parameter int unsigned FRAME_W  = VGA_FRAME_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         pattern_sel,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               video_active,
  output logic [7:0]         vga_bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] V_END    = POS_W'(V_TOTAL);
  localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] HS_END   = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] VS_END   = POS_W'(V_ACTIVE + V_FP + V_SYNC);

  pattern_e         pat_q;
  logic             h_wrap;
  logic             v_last;
  logic             v_oob;
  logic             frame_wrap;
  logic [POS_W-1:0] hpos_nxt;
  logic [POS_W-1:0] vpos_nxt;
  logic             active_d;
  logic             hs_on;
  logic             vs_on;
  logic             hs_lvl;
  logic             vs_lvl;
  rgb_t             rgb_d;
  rgb_t             rgb_vis;

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .FRAME_W  (FRAME_W)
  ) u_pattern (
    .hpos      (hpos),
    .vpos      (vpos),
    .frame_cnt (frame_cnt),
    .pattern   (pat_q),
    .rgb       (rgb_d)
  );

  always_comb begin
    // ">=" rather than "==" so a corrupted counter falls back to 0 on the next step.
    h_wrap     = (hpos >= H_LAST);
    v_last     = (vpos >= V_LAST);
    v_oob      = (vpos >= V_END);
    frame_wrap = h_wrap && v_last;

    hpos_nxt = h_wrap ? '0 : hpos + POS_W'(1);
    if (v_oob) begin
      vpos_nxt = '0;
    end else if (h_wrap) begin
      vpos_nxt = v_last ? '0 : vpos + POS_W'(1);
    end else begin
      vpos_nxt = vpos;
    end

    active_d = (hpos < H_VIS) && (vpos < V_VIS);
    hs_on    = (hpos >= HS_FIRST) && (hpos < HS_END);
    vs_on    = (vpos >= VS_FIRST) && (vpos < VS_END);
    hs_lvl   = hs_on ? SYNC_POL : ~SYNC_POL;
    vs_lvl   = vs_on ? SYNC_POL : ~SYNC_POL;
    rgb_vis  = active_d ? rgb_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos         <= '0;
      vpos         <= '0;
      frame_cnt    <= '0;
      pat_q        <= PAT_BLACK;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      video_active <= 1'b0;
      vga_bus      <= pack_bus('0, ~SYNC_POL, ~SYNC_POL);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        hpos <= hpos_nxt;
        vpos <= vpos_nxt;
        if (frame_wrap) begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
          // New pattern only takes effect from pixel (0,0) of the next frame.
          pat_q     <= pattern_e'(pattern_sel);
        end
        // Outputs are the decode of the pre-increment position, one enabled cycle behind.
        line_start   <= (hpos == '0);
        frame_start  <= (hpos == '0) && (vpos == '0);
        hsync        <= hs_lvl;
        vsync        <= vs_lvl;
        video_active <= active_d;
        vga_bus      <= pack_bus(rgb_vis, hs_lvl, vs_lvl);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen
module tb_vga_timing_gen;

  localparam int HA = 640;
  localparam int HF = 16;
  localparam int HS = 96;
  localparam int HB = 48;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 8;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    pattern_sel;
  logic [9:0]    hpos;
  logic [9:0]    vpos;
  logic [FW-1:0] frame_cnt;
  logic          line_start;
  logic          frame_start;
  logic          hsync;
  logic          vsync;
  logic          video_active;
  logic [7:0]    vga_bus;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0), .FRAME_W (FW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .pattern_sel  (pattern_sel),
    .hpos         (hpos),
    .vpos         (vpos),
    .frame_cnt    (frame_cnt),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_active (video_active),
    .vga_bus      (vga_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]    hpos;
    logic [9:0]    vpos;
    logic [FW-1:0] frame;
    logic          ls;
    logic          fs;
    logic          hs;
    logic          vs;
    logic          act;
    logic [7:0]    bus;
  } obs_t;

  obs_t        sb_q[$];
  obs_t        exp_cur;
  int unsigned n_en;
  int          frame_pat [0:15];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic obs_t reset_obs();
    obs_t o;
    o     = '0;
    o.hs  = 1'b1;
    o.vs  = 1'b1;
    o.bus = 8'h11;
    return o;
  endfunction

  // Position k = number of enabled edges since reset; outputs after an edge
  // describe the position before it, counters show the position after it.
  function automatic obs_t model_obs(input int unsigned prev, input int unsigned cur);
    obs_t o;
    int h, v, f, p, bar, r, g, b;
    bit act, hs_on, vs_on;
    h = int'(prev % HT);
    v = int'((prev / HT) % VT);
    f = int'((prev / FT) % (1 << FW));
    p = frame_pat[(prev / FT) % 16];
    act   = (h < HA) && (v < VA);
    hs_on = (h >= HA + HF) && (h < HA + HF + HS);
    vs_on = (v >= VA + VF) && (v < VA + VF + VS);
    r = 0; g = 0; b = 0;
    case (p)
      1: begin
        bar = h / (HA / 8);
        r = ((bar >> 2) & 1) * 3;
        g = ((bar >> 1) & 1) * 3;
        b = (bar & 1) * 3;
      end
      2: if ((((h >> 5) ^ (v >> 5)) & 1) != 0) begin r = 3; g = 3; b = 3; end
      3: begin
        r = ((h + f) >> 6) & 3;
        g = (v >> 6) & 3;
        b = ((h - f + 1024) >> 6) & 3;
      end
      default: ;
    endcase
    if (!act) begin r = 0; g = 0; b = 0; end
    o.hpos  = 10'(cur % HT);
    o.vpos  = 10'((cur / HT) % VT);
    o.frame = FW'((cur / FT) % (1 << FW));
    o.ls    = (h == 0);
    o.fs    = (h == 0) && (v == 0);
    o.hs    = !hs_on;
    o.vs    = !vs_on;
    o.act   = act;
    o.bus   = {r[1], g[1], b[1], !vs_on, r[0], g[0], b[0], !hs_on};
    return o;
  endfunction

  task automatic model_step();
    int unsigned prev;
    if (!rst_n) begin
      n_en = 0;
      foreach (frame_pat[i]) frame_pat[i] = 0;
      exp_cur = reset_obs();
    end else if (en) begin
      prev = n_en;
      n_en = n_en + 1;
      if (n_en % FT == 0) frame_pat[(n_en / FT) % 16] = int'(pattern_sel);
      exp_cur = model_obs(prev, n_en);
    end else begin
      exp_cur.ls = 1'b0;
      exp_cur.fs = 1'b0;
    end
    sb_q.push_back(exp_cur);
  endtask

  task automatic cycle(input logic en_v, input logic [1:0] sel_v);
    en          = en_v;
    pattern_sel = sel_v;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {hpos, vpos, frame_cnt, line_start, frame_start, hsync, vsync, video_active, vga_bus};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL sb t=%0t got h=%0d v=%0d fr=%0d ls=%b fs=%b hs=%b vs=%b act=%b bus=%h want h=%0d v=%0d fr=%0d ls=%b fs=%b hs=%b vs=%b act=%b bus=%h",
                   $time, a.hpos, a.vpos, a.frame, a.ls, a.fs, a.hs, a.vs, a.act, a.bus,
                   e.hpos, e.vpos, e.frame, e.ls, e.fs, e.hs, e.vs, e.act, e.bus);
        end
      end
    end
  end

  initial begin
    logic [27:0] got;
    rst_n       = 1'b0;
    en          = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) cycle(1'b1, 2'd0);
    rst_n = 1'b1;
    while (n_en < 300) cycle(1'b1, 2'd0);

    // Asynchronous reset mid-line: outputs must clear before any clock edge.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    got = {hpos, vpos, line_start, frame_start, hsync, vsync, video_active, vga_bus};
    n_cmp++;
    if (got !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11}) begin
      n_bad++;
      $display("FAIL async_reset got %h want %h", got, {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11});
    end
    repeat (2) cycle(1'b1, 2'd2);
    rst_n = 1'b1;

    // Frame 0 black, 1 bars (with a mid-frame request for checker), 2 checker,
    // 3 gradient, then random patterns across the frame-counter wrap.
    for (int c = 0; c < 80000 && n_en < 4 * FT + 2 * HT; c++) begin
      int         fi;
      int         ln;
      logic       e_v;
      logic [1:0] s_v;
      fi = int'(n_en / FT);
      ln = int'((n_en / HT) % VT);
      case (fi)
        0:       begin e_v = 1'b1; s_v = 2'd1; end
        1:       begin e_v = 1'b1; s_v = (ln < 3) ? 2'd1 : 2'd2; end
        2:       begin e_v = ($urandom % 8) != 0; s_v = 2'd3; end
        default: begin e_v = ($urandom % 4) != 0; s_v = 2'($urandom); end
      endcase
      cycle(e_v, s_v);
    end
    n_cmp++;
    if (n_en < 4 * FT + 2 * HT) begin
      n_bad++;
      $display("FAIL budget got %0d enabled cycles want %0d", n_en, 4 * FT + 2 * HT);
    end

    repeat (4) cycle(1'b0, 2'd0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
